serializer49to10: RTL and testbench
===================================

Name: serializer49to10

Overview:
Width gearbox from 49-bit words down to 10-bit words. It is the transmit-side counterpart of the 10-to-49 deserializer. Each frame of 10 input words (490 bits) leaves as 49 output words, LSB-first, so the far-end deserializer rebuilds the same 49-bit words. It sits between the 49-bit payload source and the 10-bit line/link interface, with valid/ready on both sides.

Parameters:
IN_W, 49, input word width
OUT_W, 10, output word width
FRAME_IN, 10, input words per frame
FRAME_OUT, 49, output words per frame
Constraints, checked at elaboration: IN_W*FRAME_IN == OUT_W*FRAME_OUT, and IN_W >= OUT_W.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous, active-low reset
in_data  in  IN_W  payload word; bit 0 is transmitted first
in_valid  in  1  in_data is valid
in_ready  out  1  word accepted when in_valid && in_ready
out_data  out  OUT_W  line word; bit 0 is first in the stream
out_valid  out  1  out_data is valid
out_ready  in  1  word consumed when out_valid && out_ready
out_sof  out  1  out_valid && this is output word 0 of a frame
out_eof  out  1  out_valid && this is output word FRAME_OUT-1 of a frame

Behaviour:
- State registers:
  - buf[BUF_W-1:0], BUF_W = IN_W+OUT_W-1 = 58
  - cnt, count of valid bits, range 0..58
  - ocnt, output word index, range 0..FRAME_OUT-1
- Reset (rst_n low at a clk edge): buf=0, cnt=0, ocnt=0. This gives out_valid=0, out_data=0, out_sof=0, out_eof=0, and in_ready=1 once rst_n is high.
- Output decode:
  - out_data = buf[OUT_W-1:0]
  - out_valid = (cnt >= OUT_W)
  - out_sof = out_valid && ocnt==0
  - out_eof = out_valid && ocnt==FRAME_OUT-1
  - All outputs derive from registers only.
- pop = out_valid && out_ready.
  - On pop: buf shifts right by OUT_W (zero fill), cnt -= OUT_W, ocnt increments and wraps from FRAME_OUT-1 to 0.
- in_ready = (cnt < OUT_W) || (cnt < 2*OUT_W && out_ready).
  - This is a combinational path from out_ready, and it is intentional.
  - in_ready is high exactly when the post-pop residue is below OUT_W.
- push = in_valid && in_ready.
  - in_data is written at bit position r = cnt - (pop ? OUT_W : 0), i.e. buf[r+IN_W-1:r].
  - cnt_next = r + IN_W. Bits above r+IN_W-1 are zero.
- Simultaneous push and pop: the shift and the insert happen in the same cycle. Example: cnt=19 with pop and push gives cnt=58, with the new word at bits 57:9.
- Latency: a word accepted with cnt=0 drives out_valid=1 with its bits 9:0 on the next cycle.
- Throughput: with in_valid and out_ready held high, out_valid never deasserts after the first word. Exactly FRAME_IN words are accepted per FRAME_OUT output cycles.
- Frame alignment: because 490 = 10*49, the residue is 0 at every frame boundary. ocnt==0 therefore coincides with output bit 0 of input word 0 of the frame.
- Underflow: if the source stalls, out_valid drops when cnt < 10. Residue bits are held, never padded or emitted.
- Overflow: impossible by construction; cnt never exceeds 58.
- Reset mid-frame: the partial frame is discarded. The first word accepted after reset starts a new frame, and its first output has out_sof=1.
- If out_valid && !out_ready: out_data, out_sof and out_eof stay stable until the pop.

Decomposition:
- Shared package holds:
  - IN_W, OUT_W, FRAME_IN, FRAME_OUT
  - derived BUF_W and CNT_W = $clog2(BUF_W+1)
  - the bit-order convention (LSB-first stream)
  - The 10-to-49 deserializer imports the same constants.
- One sub-module: gearbox_frame_ctr, a wrapping index counter with an inc enable and synchronous reset. It produces the first/last flags and is reused for ocnt here and for the deserializer's counters.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks, then release -> out_valid=0, out_data=0, out_sof=0, in_ready=1 on the first cycle after release.
- Single word: in_data=49'h1_2345_6789_ABCD, one beat, out_ready=1 ->
  - next cycle out_data=10'h3CD with out_sof=1
  - exactly 4 consecutive valid words follow the push
  - then out_valid=0 with cnt=9 held
  - concatenated output bits equal in_data[39:0]
- Full frame streaming: 10 words with value i*49'h0_0000_0101_0101, in_valid and out_ready held 1 ->
  - 49 consecutive out_valid cycles
  - out_sof only on word 0, out_eof only on word 48
  - in_ready high exactly 10 times per 49 cycles
  - output concatenation is bit-exact to the 490 input bits
- Simultaneous push/pop: drive cnt=19 with pop and push of 49'h1_FFFF_FFFF_FFFF -> cnt=58, low 9 bits retained, next output word = {1'b1, old residue[8:0]}.
- Backpressure: out_ready random at 30% high and in_valid random, over 100 frames ->
  - no lost or duplicated bits
  - out_data stable while stalled
  - cnt <= 58 at all times
  - out_sof exactly every 49 pops
- Reset mid-frame: rst_n=0 for 1 clock at output word 20 ->
  - next cycle out_valid=0
  - after a new push, the first output has out_sof=1 and carries bits 9:0 of the new word

Source files
------------

// File: rtl/serializer49to10_pkg.sv
// serializer49to10_pkg: shared gearbox constants for the 49<->10 serializer/deserializer pair.
package serializer49to10_pkg;

    localparam int IN_W      = 49;
    localparam int OUT_W     = 10;
    localparam int FRAME_IN  = 10;
    localparam int FRAME_OUT = 49;
    localparam int BUF_W     = IN_W + OUT_W - 1;
    localparam int CNT_W     = $clog2(BUF_W + 1);

    // Wire order of the serial stream: bit 0 of every word goes out first.
    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } bit_order_e;

    localparam bit_order_e BIT_ORDER = LSB_FIRST;

endpackage

// File: rtl/serializer49to10_if.sv
// serializer49to10_if: payload-side and line-side valid/ready bundle of the gearbox.
interface serializer49to10_if;
    import serializer49to10_pkg::*;

    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sof;
    logic             out_eof;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sof, out_eof
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sof, out_eof
    );

endinterface

// File: rtl/serializer49to10_frame_ctr.sv
// gearbox_frame_ctr: wrapping 0..N-1 word index with first/last flags decoded from the register.
module gearbox_frame_ctr #(
    parameter int N = 49,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    output logic first_o,
    output logic last_o
);

    logic [W-1:0] idx_q, idx_d;

    always_comb idx_d = !inc_i ? idx_q : (idx_q == W'(N - 1)) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) idx_q <= '0;
        else        idx_q <= idx_d;
    end

    assign first_o = (idx_q == '0);
    assign last_o  = (idx_q == W'(N - 1));

endmodule

// File: rtl/serializer49to10.sv
// serializer49to10: 49-bit to 10-bit LSB-first width gearbox with valid/ready on both sides.
module serializer49to10
    import serializer49to10_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    serializer49to10_if.slave  io
);

    if (IN_W * FRAME_IN != OUT_W * FRAME_OUT || IN_W < OUT_W) begin : g_bad_cfg
        $error("serializer49to10: inconsistent frame geometry");
    end

    logic [BUF_W-1:0] buf_q, buf_d, shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d, r;
    logic             pop, push, first, last;

    assign io.out_data  = buf_q[OUT_W-1:0];
    assign io.out_valid = (cnt_q >= CNT_W'(OUT_W));
    // Ready whenever the residue left after this cycle's pop leaves room for a whole word.
    assign io.in_ready  = (cnt_q < CNT_W'(OUT_W)) || ((cnt_q < CNT_W'(2 * OUT_W)) && io.out_ready);
    assign io.out_sof   = io.out_valid && first;
    assign io.out_eof   = io.out_valid && last;
    assign pop          = io.out_valid && io.out_ready;
    assign push         = io.in_valid && io.in_ready;

    // Bits above cnt are always zero, so the new word can simply be OR-ed in at the residue edge.
    always_comb begin
        shifted = pop ? (buf_q >> OUT_W) : buf_q;
        r       = pop ? (cnt_q - CNT_W'(OUT_W)) : cnt_q;
        buf_d   = push ? (shifted | (BUF_W'(io.in_data) << r)) : shifted;
        cnt_d   = push ? (r + CNT_W'(IN_W)) : r;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    gearbox_frame_ctr #(.N(FRAME_OUT)) u_ocnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (pop),
        .first_o (first),
        .last_o  (last)
    );

endmodule

// File: tb/tb_serializer49to10.sv
// tb_serializer49to10: random and directed stimulus against a bit-queue model of the 49->10 gearbox.
module tb_serializer49to10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serializer49to10_if sif ();

    serializer49to10 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (sif)
    );

    int   checks = 0;
    int   failures = 0;
    bit   bitq[$];
    int   fpos = 0;
    int   pops = 0;
    int   accepts = 0;
    bit   known = 1'b0;
    int   p0, a0, cyc;
    logic [48:0] x, y;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [48:0] rnd49();
        return 49'({$urandom(), $urandom()});
    endfunction

    // One clock: drive inputs, compare outputs against the model, then advance the model.
    task automatic step(input logic rn, input logic iv, input logic [48:0] d, input logic ordy);
        int n;
        logic ev, er;
        logic [9:0] e;
        @(negedge clk);
        rst_n = rn;
        sif.in_valid = iv;
        sif.in_data = d;
        sif.out_ready = ordy;
        #1;
        n = bitq.size();
        ev = (n >= 10);
        er = (n < 10) || ((n < 20) && ordy);
        e = '0;
        for (int i = 0; i < 10 && i < n; i++) e[i] = bitq[i];
        if (known) begin
            chk("out_valid", 64'(sif.out_valid), 64'(ev));
            chk("in_ready", 64'(sif.in_ready), 64'(er));
            chk("out_data", 64'(sif.out_data), 64'(e));
            chk("out_sof", 64'(sif.out_sof), 64'(ev && fpos == 0));
            chk("out_eof", 64'(sif.out_eof), 64'(ev && fpos == 48));
            chk("cnt", 64'(dut.cnt_q), 64'(n));
        end
        if (!rn) begin
            bitq.delete();
            fpos = 0;
            known = 1'b1;
        end else begin
            if (ev && ordy) begin
                repeat (10) void'(bitq.pop_front());
                fpos = (fpos + 1) % 49;
                pops++;
            end
            if (iv && er) begin
                for (int i = 0; i < 49; i++) bitq.push_back(d[i]);
                accepts++;
            end
        end
    endtask

    initial begin
        sif.in_valid = 1'b0;
        sif.in_data = '0;
        sif.out_ready = 1'b0;

        repeat (3) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);

        p0 = pops;
        step(1'b1, 1'b1, 49'h1_2345_6789_ABCD, 1'b1);
        @(posedge clk); #1;
        chk("single_first", 64'({sif.out_sof, sif.out_valid, sif.out_data}), 64'({1'b1, 1'b1, 10'h3CD}));
        repeat (7) step(1'b1, 1'b0, '0, 1'b1);
        chk("single_pops", 64'(pops - p0), 64'd4);
        @(posedge clk); #1;
        chk("single_cnt", 64'(dut.cnt_q), 64'd9);

        step(1'b0, 1'b0, '0, 1'b0);
        p0 = pops;
        a0 = accepts;
        cyc = 0;
        while (pops - p0 < 49 && cyc < 100) begin
            step(1'b1, 1'(accepts - a0 < 10), 49'(accepts - a0) * 49'h0_0000_0101_0101, 1'b1);
            cyc++;
        end
        chk("frame_pops", 64'(pops - p0), 64'd49);
        chk("frame_accepts", 64'(accepts - a0), 64'd10);
        chk("frame_cycles", 64'(cyc), 64'd50);

        step(1'b0, 1'b0, '0, 1'b0);
        x = rnd49();
        step(1'b1, 1'b1, x, 1'b0);
        repeat (3) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 49'h1_FFFF_FFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        chk("pp_cnt", 64'(dut.cnt_q), 64'd58);
        chk("pp_word", 64'(sif.out_data), 64'({1'b1, x[48:40]}));
        repeat (6) step(1'b1, 1'b0, '0, 1'b1);

        step(1'b0, 1'b0, '0, 1'b0);
        p0 = pops;
        cyc = 0;
        while (pops - p0 < 4900 && cyc < 40000) begin
            step(1'b1, 1'($urandom_range(0, 1)), rnd49(), 1'($urandom_range(0, 9) < 3));
            cyc++;
        end
        chk("bp_done", 64'(pops - p0 >= 4900), 64'd1);

        step(1'b0, 1'b0, '0, 1'b0);
        cyc = 0;
        while (fpos != 20 && cyc < 200) begin
            step(1'b1, 1'b1, rnd49(), 1'b1);
            cyc++;
        end
        chk("mr_reach20", 64'(fpos), 64'd20);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        y = rnd49();
        step(1'b1, 1'b1, y, 1'b1);
        @(posedge clk); #1;
        chk("mr_first", 64'({sif.out_sof, sif.out_valid, sif.out_data}), 64'({1'b1, 1'b1, y[9:0]}));
        repeat (6) step(1'b1, 1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
